l0_skew_buf: RTL and testbench

L0_SKEW_BUF -- requirements
Module: l0_skew_buf

---
 rtl/l0_skew_buf_pkg.sv | 15 +
 rtl/l0_skew_buf_if.sv | 26 ++
 rtl/l0_row_fifo.sv | 49 ++++
 rtl/l0_skew_buf.sv | 72 +++++++
 tb/tb_l0_skew_buf.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/l0_skew_buf_pkg.sv
// l0_skew_buf_pkg: read-mode encodings, error flag positions and sizing helper
package l0_skew_buf_pkg;
    typedef enum logic {
        MODE_PAR  = 1'b0,
        MODE_SKEW = 1'b1
    } mode_e;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

    // Counter width able to hold 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/l0_skew_buf_if.sv
// l0_skew_buf_if: write/read request and status bundle for the skew buffer
interface l0_skew_buf_if #(
    parameter int ROW = 8,
    parameter int BW  = 4
);
    logic              wr;
    logic [ROW*BW-1:0] in;
    logic              rd;
    logic              mode;
    logic [ROW*BW-1:0] out;
    logic [ROW-1:0]    o_valid;
    logic              o_full;
    logic              o_ready;
    logic              o_empty;
    logic [1:0]        o_err;

    modport master (
        output wr, in, rd, mode,
        input  out, o_valid, o_full, o_ready, o_empty, o_err
    );

    modport slave (
        input  wr, in, rd, mode,
        output out, o_valid, o_full, o_ready, o_empty, o_err
    );
endinterface

// File: rtl/l0_row_fifo.sv
// l0_row_fifo: single row FIFO with combinational head and occupancy count
module l0_row_fifo
    import l0_skew_buf_pkg::*;
#(
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [BW-1:0]             din,
    output logic [BW-1:0]             head,
    output logic                      full,
    output logic                      empty,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [BW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rptr];

    // Storage is left uninitialised; count gates every read of it
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/l0_skew_buf.sv
// l0_skew_buf: ROW parallel FIFOs written together, read in parallel or as a
// diagonal wave where row i pops i cycles after row 0
module l0_skew_buf
    import l0_skew_buf_pkg::*;
#(
    parameter int ROW   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64
) (
    input logic          clk,
    input logic          reset,
    l0_skew_buf_if.slave bus
);
    localparam int CW = cnt_w(DEPTH);

    logic [ROW-1:0] rd_en;
    logic [ROW-1:0] rd_en_d;
    logic [ROW-1:0] full;
    logic [ROW-1:0] empty;
    logic [ROW-1:0] zero;
    logic [ROW-1:0] pop;
    logic [BW-1:0]  head  [ROW];
    logic [CW-1:0]  count [ROW];
    logic           push;
    mode_e          mode_q;

    assign push         = bus.wr & ~bus.o_full;
    assign pop          = rd_en & ~empty;
    assign bus.o_full   = |full;
    assign bus.o_empty  = &zero;
    assign bus.o_ready  = ~bus.o_full;

    // Skewed mode shifts the request one row per cycle
    always_comb rd_en_d = (mode_q == MODE_SKEW) ? ROW'({rd_en, bus.rd}) : {ROW{bus.rd}};

    for (genvar i = 0; i < ROW; i++) begin : row_g
        l0_row_fifo #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push),
            .pop   (pop[i]),
            .din   (bus.in[BW*i +: BW]),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i]),
            .count (count[i])
        );
        assign zero[i] = count[i] == '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en       <= '0;
            mode_q      <= MODE_PAR;
            bus.o_valid <= '0;
            bus.out     <= '0;
            bus.o_err   <= '0;
        end else begin
            rd_en       <= rd_en_d;
            bus.o_valid <= pop;
            // Mode switches only between waves so a wave never changes shape
            if (!bus.rd && rd_en == '0) mode_q <= mode_e'(bus.mode);
            for (int i = 0; i < ROW; i++)
                if (pop[i]) bus.out[BW*i +: BW] <= head[i];
            if (bus.wr && bus.o_full) bus.o_err[ERR_OVF] <= 1'b1;
            if (|(rd_en & empty)) bus.o_err[ERR_UDF] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l0_skew_buf.sv
// tb_l0_skew_buf: directed and random checks of l0_skew_buf against a
// history-queue reference model
module tb_l0_skew_buf;
    localparam int ROW = 8, BW = 4, DEPTH = 64, W = ROW * BW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    l0_skew_buf_if #(.ROW(ROW), .BW(BW)) bus ();
    l0_skew_buf #(.ROW(ROW), .BW(BW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Every accepted write word is kept; row i has consumed rp[i] of them
    logic [W-1:0]   hist[$];
    int             rp[ROW];
    bit [ROW-1:0]   plan[32];
    bit             mmode;
    logic [W-1:0]   e_out;
    logic [ROW-1:0] e_valid;
    logic [1:0]     e_err;

    function automatic int sz(input int i);
        return hist.size() - rp[i];
    endfunction

    function automatic bit m_full();
        for (int i = 0; i < ROW; i++) if (sz(i) == DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_empty();
        for (int i = 0; i < ROW; i++) if (sz(i) != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < ROW; i++) rp[i] = 0;
        for (int k = 0; k < 32; k++) plan[k] = '0;
        mmode   = 1'b0;
        e_out   = '0;
        e_valid = '0;
        e_err   = '0;
    endtask

    // A read request at edge c pops row i at edge c+1 (parallel) or c+1+i (skewed)
    task automatic model_step();
        bit           was_full = m_full();
        bit           pend = 1'b0;
        bit [ROW-1:0] now = plan[cyc % 32];
        for (int k = 0; k <= ROW; k++) if (plan[(cyc + k) % 32] != '0) pend = 1'b1;
        e_valid = '0;
        for (int i = 0; i < ROW; i++) begin
            if (now[i]) begin
                if (sz(i) > 0) begin
                    e_out[BW*i +: BW] = hist[rp[i]][BW*i +: BW];
                    rp[i]++;
                    e_valid[i] = 1'b1;
                end else e_err[1] = 1'b1;
            end
        end
        plan[cyc % 32] = '0;
        if (bus.wr) begin
            if (was_full) e_err[0] = 1'b1;
            else hist.push_back(bus.in);
        end
        if (bus.rd) begin
            for (int i = 0; i < ROW; i++) plan[(cyc + 1 + (mmode ? i : 0)) % 32][i] = 1'b1;
        end else if (!pend) mmode = bus.mode;
        cyc++;
    endtask

    task automatic check_all(input string tag);
        check({tag, " out"}, bus.out, e_out);
        check({tag, " valid"}, bus.o_valid, e_valid);
        check({tag, " err"}, bus.o_err, e_err);
        check({tag, " full"}, bus.o_full, m_full());
        check({tag, " empty"}, bus.o_empty, m_empty());
        check({tag, " ready"}, bus.o_ready, !m_full());
    endtask

    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit m, input string tag);
        bus.wr   = w;
        bus.in   = d;
        bus.rd   = r;
        bus.mode = m;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int first[ROW];
        int last7;
        bit m;
        bus.wr   = 1'b0;
        bus.in   = '0;
        bus.rd   = 1'b0;
        bus.mode = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        #11 check_all("reset");
        #11 reset = 1'b1;

        // Parallel read of one word
        step(1'b1, 32'h76543210, 1'b0, 1'b0, "w36");
        step(1'b0, $urandom, 1'b1, 1'b0, "rd36");
        step(1'b0, $urandom, 1'b0, 1'b0, "pop36");
        check("r36 valid", bus.o_valid, 8'hFF);
        check("r36 out", bus.out, 32'h76543210);
        check("r36 empty", bus.o_empty, 1'b1);

        // Read of an empty buffer
        step(1'b0, $urandom, 1'b1, 1'b0, "udf rd");
        step(1'b0, $urandom, 1'b0, 1'b0, "udf pop");
        check("udf valid", bus.o_valid, 8'h00);
        check("udf out", bus.out, 32'h76543210);
        check("udf err", bus.o_err[1], 1'b1);

        // Same-cycle push and pop on an empty row: no bypass
        async_reset("rst a");
        step(1'b0, $urandom, 1'b1, 1'b0, "wr+rd arm");
        step(1'b1, $urandom, 1'b0, 1'b0, "wr+rd");
        check("wr+rd err", bus.o_err, 2'b10);
        check("wr+rd nonempty", bus.o_empty, 1'b0);
        step(1'b0, $urandom, 1'b1, 1'b0, "wr+rd drain rd");
        step(1'b0, $urandom, 1'b0, 1'b0, "wr+rd drain");
        check("wr+rd drained", bus.o_empty, 1'b1);

        // Skewed wave
        async_reset("rst b");
        step(1'b0, $urandom, 1'b0, 1'b1, "skew mode");
        for (int k = 0; k < 8; k++) step(1'b1, $urandom, 1'b0, 1'b1, "skew wr");
        for (int i = 0; i < ROW; i++) first[i] = -1;
        last7 = -1;
        for (int k = 0; k < 17; k++) begin
            step(1'b0, $urandom, k < 8, 1'b1, "skew rd");
            for (int i = 0; i < ROW; i++) if (bus.o_valid[i] && first[i] < 0) first[i] = k;
            if (bus.o_valid[7]) last7 = k;
        end
        for (int i = 0; i < ROW; i++) check($sformatf("skew first%0d", i), first[i], i + 1);
        check("skew last7", last7, 15);
        check("skew err", bus.o_err, 2'b00);

        // Mode toggled mid-wave takes effect only after the wave drains
        for (int k = 0; k < 8; k++) step(1'b1, $urandom, 1'b0, 1'b1, "tog wr");
        step(1'b0, $urandom, 1'b1, 1'b0, "tog rd0");
        step(1'b0, $urandom, 1'b1, 1'b0, "tog rd1");
        for (int k = 0; k < 10; k++) step(1'b0, $urandom, 1'b0, 1'b0, "tog drain");
        step(1'b1, $urandom, 1'b0, 1'b0, "tog wr2");
        step(1'b0, $urandom, 1'b1, 1'b0, "tog par rd");
        step(1'b0, $urandom, 1'b0, 1'b0, "tog par pop");
        check("tog par valid", bus.o_valid, 8'hFF);

        // Fill to capacity, overflow, read back in order
        async_reset("rst c");
        for (int k = 0; k < DEPTH; k++) step(1'b1, $urandom, 1'b0, 1'b0, "fill");
        check("fill full", bus.o_full, 1'b1);
        check("fill ready", bus.o_ready, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0, "ovf");
        check("ovf err", bus.o_err, 2'b01);
        for (int k = 0; k < DEPTH + 2; k++) step(1'b0, $urandom, k < DEPTH, 1'b0, "drain");
        check("drain empty", bus.o_empty, 1'b1);

        // Asynchronous reset in the middle of a skewed wave
        async_reset("rst d");
        step(1'b0, $urandom, 1'b0, 1'b1, "mid mode");
        for (int k = 0; k < 8; k++) step(1'b1, $urandom, 1'b0, 1'b1, "mid wr");
        for (int k = 0; k < 4; k++) step(1'b0, $urandom, 1'b1, 1'b1, "mid rd");
        async_reset("mid rst");
        check("mid rst out", bus.out, 32'h0);
        check("mid rst valid", bus.o_valid, 8'h00);
        for (int k = 0; k < 10; k++) step(1'b0, $urandom, 1'b0, 1'b0, "mid after");
        check("mid empty", bus.o_empty, 1'b1);
        check("mid valid", bus.o_valid, 8'h00);

        // Random traffic
        async_reset("rst e");
        m = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(19) == 0) m = ~m;
            step($urandom_range(1) == 1, $urandom, $urandom_range(9) < 4, m, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
